// File: rtl/kyber_pkg.sv
// Shared Kyber constants, coefficient type and canonical-range helper.
// Used by ntt_butterfly and mont_reduce.
package kyber_pkg;

  localparam int KYBER_Q      = 3329;
  localparam int KYBER_QINV   = -3327;
  localparam int KYBER_MONT_R = 2285;

  typedef logic signed [15:0] coeff_t;

  // Folds a value in (-q, 2q) into [0, q-1].
  function automatic coeff_t mod_norm(input logic signed [16:0] x);
    logic signed [16:0] r;
    if (x < 0) begin
      r = x + 17'(KYBER_Q);
    end else if (x >= 17'(KYBER_Q)) begin
      r = x - 17'(KYBER_Q);
    end else begin
      r = x;
    end
    return coeff_t'(16'(r));
  endfunction

endpackage

// File: rtl/ntt_butterfly_if.sv
// Coefficient-pair stream into and out of the NTT butterfly.
// The inv lane exists only when NTT_INTT_EN is defined.
interface ntt_butterfly_if #(
  parameter int unsigned ADDR_W = 8
);
  import kyber_pkg::*;

  logic              in_valid;
  logic              in_ready;
  coeff_t            a_in;
  coeff_t            b_in;
  coeff_t            zeta_in;
  logic [ADDR_W-1:0] addr1_in;
  logic [ADDR_W-1:0] addr2_in;
`ifdef NTT_INTT_EN
  logic              inv;
`endif
  logic              out_valid;
  logic              out_ready;
  coeff_t            a_out;
  coeff_t            b_out;
  logic [ADDR_W-1:0] addr1_out;
  logic [ADDR_W-1:0] addr2_out;

  modport slave (
    input  in_valid, a_in, b_in, zeta_in, addr1_in, addr2_in, out_ready,
`ifdef NTT_INTT_EN
    input  inv,
`endif
    output in_ready, out_valid, a_out, b_out, addr1_out, addr2_out
  );

  modport master (
    output in_valid, a_in, b_in, zeta_in, addr1_in, addr2_in, out_ready,
`ifdef NTT_INTT_EN
    output inv,
`endif
    input  in_ready, out_valid, a_out, b_out, addr1_out, addr2_out
  );

endinterface

// File: rtl/mont_reduce.sv
// Combinational Montgomery reduction: t = p * 2^-16 mod q, result in (-q, q).
// Shared with the pointwise-multiply block.
module mont_reduce
  import kyber_pkg::*;
(
  input  logic signed [31:0] p,
  output coeff_t             t
);

  localparam logic [15:0] QINV16 = 16'(KYBER_QINV);

  logic [15:0]        u;
  logic signed [31:0] uq;
  logic signed [31:0] diff;

  always_comb begin
    u    = p[15:0] * QINV16;
    uq   = 32'($signed(u)) * KYBER_Q;
    // Low 16 bits of diff are zero by construction, so the shift is exact.
    diff = p - uq;
    t    = coeff_t'(16'(diff >>> 16));
  end

endmodule

// File: rtl/ntt_butterfly.sv
// Three-stage Kyber Cooley-Tukey butterfly with in-place address tags and a global stall.
// Defining NTT_INTT_EN adds the Gentleman-Sande (inverse) mode selected per pair by bus.inv.
module ntt_butterfly
  import kyber_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input logic              clk,
  input logic              reset,
  ntt_butterfly_if.slave   bus
);

  logic stall;
  logic en;

  logic                     v1_q, v2_q, v3_q;
  logic signed [DATA_W-1:0] a1_q, b1_q, z1_q;
  logic signed [DATA_W-1:0] a2_q;
  logic signed [31:0]       p2_q;
  logic [ADDR_W-1:0]        ad1_1_q, ad2_1_q, ad1_2_q, ad2_2_q, ad1_3_q, ad2_3_q;
  coeff_t                   a3_q, b3_q;
`ifdef NTT_INTT_EN
  logic                     inv1_q, inv2_q;
`endif

  logic signed [31:0]       p_d;
  logic signed [DATA_W-1:0] a2_d;
  coeff_t                   t2;
  coeff_t                   a3_d, b3_d;

  assign stall        = v3_q & ~bus.out_ready;
  assign en           = ~stall;
  assign bus.in_ready = en;

  always_comb begin
    p_d  = 32'(b1_q) * 32'(z1_q);
    a2_d = a1_q;
`ifdef NTT_INTT_EN
    // Inverse mode: sum is final here and rides stage 2 to keep latency at 3.
    if (inv1_q) begin
      a2_d = mod_norm(17'(a1_q) + 17'(b1_q));
      p_d  = 32'(mod_norm(17'(a1_q) - 17'(b1_q))) * 32'(z1_q);
    end
`endif
  end

  mont_reduce u_mont_reduce (
    .p (p2_q),
    .t (t2)
  );

  always_comb begin
    a3_d = mod_norm(17'(a2_q) + 17'(t2));
    b3_d = mod_norm(17'(a2_q) - 17'(t2));
`ifdef NTT_INTT_EN
    if (inv2_q) begin
      a3_d = a2_q;
      b3_d = mod_norm(17'(t2));
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      a1_q    <= '0;
      b1_q    <= '0;
      z1_q    <= '0;
      a2_q    <= '0;
      p2_q    <= '0;
      ad1_1_q <= '0;
      ad2_1_q <= '0;
      ad1_2_q <= '0;
      ad2_2_q <= '0;
      ad1_3_q <= '0;
      ad2_3_q <= '0;
      a3_q    <= '0;
      b3_q    <= '0;
`ifdef NTT_INTT_EN
      inv1_q  <= 1'b0;
      inv2_q  <= 1'b0;
`endif
    end else if (en) begin
      v1_q <= bus.in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (bus.in_valid) begin
        a1_q    <= bus.a_in;
        b1_q    <= bus.b_in;
        z1_q    <= bus.zeta_in;
        ad1_1_q <= bus.addr1_in;
        ad2_1_q <= bus.addr2_in;
`ifdef NTT_INTT_EN
        inv1_q  <= bus.inv;
`endif
      end
      if (v1_q) begin
        a2_q    <= a2_d;
        p2_q    <= p_d;
        ad1_2_q <= ad1_1_q;
        ad2_2_q <= ad2_1_q;
`ifdef NTT_INTT_EN
        inv2_q  <= inv1_q;
`endif
      end
      if (v2_q) begin
        a3_q    <= a3_d;
        b3_q    <= b3_d;
        ad1_3_q <= ad1_2_q;
        ad2_3_q <= ad2_2_q;
      end
    end
  end

  assign bus.out_valid = v3_q;
  assign bus.a_out     = a3_q;
  assign bus.b_out     = b3_q;
  assign bus.addr1_out = ad1_3_q;
  assign bus.addr2_out = ad2_3_q;

endmodule

// File: tb/tb_ntt_butterfly.sv
// Self-checking bench for ntt_butterfly (forward mode): randomized traffic against a
// plain modular-arithmetic scoreboard plus literal spot checks.
module tb_ntt_butterfly;
  import kyber_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  ntt_butterfly_if #(.ADDR_W(8)) bus ();

  ntt_butterfly #(
    .ADDR_W (8),
    .DATA_W (16)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int a;
    int b;
    int ad1;
    int ad2;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   out_cnt  = 0;
  logic held     = 1'b0;
  int   pa, pb, p1, p2;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // a +/- b*zeta/R mod q, with 169 = 2^-16 mod 3329.
  function automatic exp_t model(input int a, input int b, input int z,
                                 input int ad1, input int ad2);
    longint bz;
    exp_t   e;
    bz    = ((longint'(b) * z) % KYBER_Q) * 169 % KYBER_Q;
    e.a   = int'((a + bz) % KYBER_Q);
    e.b   = int'((a - bz + KYBER_Q) % KYBER_Q);
    e.ad1 = ad1;
    e.ad2 = ad2;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_out_valid", int'(bus.out_valid), 0);
      check("reset_a_out", int'(bus.a_out), 0);
      check("reset_b_out", int'(bus.b_out), 0);
      exp_q.delete();
      held = 1'b0;
    end else begin
      check("in_ready", int'(bus.in_ready), int'(!(bus.out_valid && !bus.out_ready)));
      if (held) begin
        check("hold_valid", int'(bus.out_valid), 1);
        check("hold_a_out", int'(bus.a_out), pa);
        check("hold_b_out", int'(bus.b_out), pb);
        check("hold_addr1", int'(bus.addr1_out), p1);
        check("hold_addr2", int'(bus.addr2_out), p2);
      end
      if (bus.out_valid) begin
        check("out_has_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          check("a_out", int'(bus.a_out), exp_q[0].a);
          check("b_out", int'(bus.b_out), exp_q[0].b);
          check("addr1_out", int'(bus.addr1_out), exp_q[0].ad1);
          check("addr2_out", int'(bus.addr2_out), exp_q[0].ad2);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            out_cnt++;
          end
        end
      end
      held = bus.out_valid && !bus.out_ready;
      pa   = int'(bus.a_out);
      pb   = int'(bus.b_out);
      p1   = int'(bus.addr1_out);
      p2   = int'(bus.addr2_out);
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(int'(bus.a_in), int'(bus.b_in), int'(bus.zeta_in),
                              int'(bus.addr1_in), int'(bus.addr2_in)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int a, input int b, input int z,
                       input int ad1, input int ad2);
    bus.in_valid = v;
    bus.a_in     = 16'(a);
    bus.b_in     = 16'(b);
    bus.zeta_in  = 16'(z);
    bus.addr1_in = 8'(ad1);
    bus.addr2_in = 8'(ad2);
  endtask

  task automatic drive_rand(input logic v);
    drive(v, int'($urandom_range(0, 3328)), int'($urandom_range(0, 3328)),
          int'($urandom_range(0, 3328)), int'($urandom_range(0, 255)),
          int'($urandom_range(0, 255)));
  endtask

  task automatic directed(input string nm, input int a, input int b, input int z,
                          input int ea, input int eb);
    int lat = 0;
    int ad1 = int'($urandom_range(0, 255));
    int ad2 = int'($urandom_range(0, 255));
    bus.out_ready = 1'b1;
    drive(1'b1, a, b, z, ad1, ad2);
    repeat (8) begin
      tick();
      bus.in_valid = 1'b0;
      lat++;
      if (bus.out_valid) break;
    end
    check({nm, "_latency"}, lat, 3);
    check({nm, "_a_out"}, int'(bus.a_out), ea);
    check({nm, "_b_out"}, int'(bus.b_out), eb);
    check({nm, "_addr1"}, int'(bus.addr1_out), ad1);
    check({nm, "_addr2"}, int'(bus.addr2_out), ad2);
    tick();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   base;
    logic acc;
    drive(1'b0, 0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    directed("basic", 5, 7, 2285, 12, 3327);
    directed("wrap", 3328, 1, 2285, 0, 3327);
    directed("zero_twiddle", 100, 200, 0, 100, 100);

    // Back-to-back stream with downstream always ready.
    base = out_cnt;
    for (int i = 0; i < 256; i++) begin
      drive_rand(1'b1);
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (5) tick();
    check("stream_count", out_cnt - base, 256);

    // Three in flight, then a five-cycle output stall with a pending input.
    base = out_cnt;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b1);
      tick();
    end
    drive_rand(1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", int'(bus.in_ready), 0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (6) tick();
    check("bp_count", out_cnt - base, 4);
    check("bp_queue_empty", exp_q.size(), 0);

    // Random valid/ready traffic; upstream holds a pair until it is taken.
    acc = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (!bus.in_valid || acc) drive_rand(logic'($urandom_range(0, 9) < 7));
      bus.out_ready = logic'($urandom_range(0, 9) < 7);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (8) tick();
    check("random_queue_empty", exp_q.size(), 0);

    // Reset with one result on the output and two behind it.
    base = out_cnt;
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b1);
      tick();
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset_mid_out_valid", int'(bus.out_valid), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (8) tick();
    check("reset_mid_no_stale", out_cnt - base, 0);

    directed("post_reset", 3000, 3000, 1234,
             model(3000, 3000, 1234, 0, 0).a, model(3000, 3000, 1234, 0, 0).b);
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
